axi_read_arbiter: RTL
=====================

// Module: axi_read_arbiter
// PURPOSE
//  2:1 AXI4 read-channel arbiter between the CPU's IFU (burst instruction fetch) and LSU (single-beat
//  load). Drives the single io_master AR/R channel that feeds the simulation memory slave.
//  Snoops the master AW/B channels so that no read is issued while a write is outstanding.
// PARAMETERS
//  AW      32  address width
//  DW      32  data width
//  MAXOUT  3   max outstanding writes tracked (wcnt width = $clog2(MAXOUT+1))
// PORTS
//  clock               in   1      single clock, all logic on posedge
//  reset_n             in   1      asynchronous, active-low reset
//  ifu_arvalid/arready in/out 1/1  IFU read address handshake
//  ifu_araddr          in   AW     IFU address, word aligned
//  ifu_arlen           in   8      IFU burst length-1 (INCR)
//  ifu_rvalid/rready   out/in 1/1  IFU read data handshake
//  ifu_rdata/rresp     out  DW/2   IFU read data and response
//  ifu_rlast           out  1      last beat of IFU burst
//  lsu_arvalid/arready in/out 1/1  LSU read address handshake
//  lsu_araddr          in   AW     LSU address
//  lsu_arsize          in   3      LSU access size
//  lsu_rvalid/rready   out/in 1/1  LSU read data handshake
//  lsu_rdata/rresp     out  DW/2   LSU read data and response
//  m_arvalid/arready   out/in 1/1  master AR handshake
//  m_araddr/arlen      out  AW/8   master address, burst length-1
//  m_arsize/arburst    out  3/2    size; burst (IFU 2'b01 INCR, LSU 2'b00 FIXED)
//  m_arid              out  4      4'd0 IFU, 4'd1 LSU
//  m_rvalid/rready     in/out 1/1  master R handshake
//  m_rdata/rresp/rlast in   DW/2/1 master read data
//  m_awvalid/awready   in   1/1    snooped write-address handshake
//  m_bvalid/bready     in   1/1    snooped write-response handshake
// BEHAVIOUR
//  Reset: state=IDLE, wcnt=0; all *valid/*ready outputs 0, m_araddr/arlen/arsize/arburst/arid 0.
//  FSM states: IDLE, AR_IFU, AR_LSU, R_IFU, R_LSU.
//   IDLE: if wcnt==0 and lsu_arvalid -> AR_LSU; else if wcnt==0 and ifu_arvalid -> AR_IFU.
//         LSU has fixed priority; simultaneous requests grant LSU.
//   AR_x: m_ar* registered from the granted master on entry, m_arvalid=1; requester's arready
//         pulses 1 cycle in the same cycle as m_arvalid&m_arready. On fire -> R_x.
//   R_x:  m_rvalid/m_rdata/rresp routed combinationally to x; m_rready=x_rready; other master's
//         rvalid=0. On m_rvalid&m_rready&m_rlast -> IDLE. No re-arbitration mid-burst.
//  Requester address is sampled only at grant; requester must hold arvalid until arready.
//  Latency: request in IDLE -> m_arvalid next cycle; 0-cycle R path (no buffering).
//  wcnt: +1 on m_awvalid&m_awready, -1 on m_bvalid&m_bready; both in one cycle -> unchanged.
//   Saturates at MAXOUT (no inc); no dec at 0. New grants blocked while wcnt!=0; a grant
//   already in AR_x/R_x completes regardless of writes beginning meanwhile.
//  rresp != 0 passed through unchanged; FSM does not abort bursts on error.
//  reset_n low mid-transaction: immediate return to reset state; in-flight beats lost.
//  m_rvalid in IDLE/AR_x (protocol violation): m_rready=0, data ignored.
// TESTING
//  1. IFU araddr=0x8000_0000 arlen=3 -> m_arlen=3 arburst=01 arid=0; 4 beats to IFU, rlast on 4th, IDLE.
//  2. IFU and LSU arvalid same cycle -> LSU (arid=1, arburst=00, arlen=0) first, IFU granted after LSU beat.
//  3. LSU arvalid during IFU burst beat 2 -> no LSU grant until IFU rlast; then AR_LSU next cycle.
//  4. AW fire then LSU arvalid -> m_arvalid held 0 until B fire; then issued within 2 cycles.
//  5. AW and B fire same cycle with wcnt=1 -> wcnt stays 1; reads remain blocked.
//  6. reset_n low during R_IFU beat 1 -> all valids 0 immediately; after release, IFU request served.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// Bundle of the IFU/LSU read ports, the shared io_master read channel and the
// snooped write handshakes around the read arbiter.
interface axi_read_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          ifu_arvalid, ifu_arready;
  logic [AW-1:0] ifu_araddr;
  logic [7:0]    ifu_arlen;
  logic          ifu_rvalid, ifu_rready, ifu_rlast;
  logic [DW-1:0] ifu_rdata;
  logic [1:0]    ifu_rresp;

  logic          lsu_arvalid, lsu_arready;
  logic [AW-1:0] lsu_araddr;
  logic [2:0]    lsu_arsize;
  logic          lsu_rvalid, lsu_rready;
  logic [DW-1:0] lsu_rdata;
  logic [1:0]    lsu_rresp;

  logic          m_arvalid, m_arready;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic [3:0]    m_arid;
  logic          m_rvalid, m_rready, m_rlast;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_awvalid, m_awready, m_bvalid, m_bready;

  // arbiter side: masters the memory read channel, serves IFU/LSU
  modport master (
    input  ifu_arvalid, ifu_araddr, ifu_arlen, ifu_rready,
    output ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, ifu_rlast,
    input  lsu_arvalid, lsu_araddr, lsu_arsize, lsu_rready,
    output lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp,
    output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready,
    input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    input  m_awvalid, m_awready, m_bvalid, m_bready
  );

  // environment side: requesters, memory slave and write traffic
  modport slave (
    output ifu_arvalid, ifu_araddr, ifu_arlen, ifu_rready,
    input  ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, ifu_rlast,
    output lsu_arvalid, lsu_araddr, lsu_arsize, lsu_rready,
    input  lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp,
    input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready,
    output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    output m_awvalid, m_awready, m_bvalid, m_bready
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// 2:1 AXI4 read arbiter (LSU fixed priority over IFU) onto one master read
// channel; new grants are held off while any snooped write is outstanding.
module axi_read_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int MAXOUT = 3
) (
  input logic               clock,
  input logic               reset_n,
  axi_read_arbiter_if.master bus
);
  localparam int         WCW      = $clog2(MAXOUT + 1);
  localparam logic [2:0] IFU_SIZE = 3'($clog2(DW / 8));

  typedef enum logic [2:0] {IDLE, AR_IFU, AR_LSU, R_IFU, R_LSU} state_t;

  state_t        r_state, w_next;
  logic [WCW-1:0] r_wcnt;
  logic [AW-1:0] r_araddr;
  logic [7:0]    r_arlen;
  logic [2:0]    r_arsize;
  logic [1:0]    r_arburst;
  logic [3:0]    r_arid;
  logic          w_aw_fire, w_b_fire, w_grant_ok, w_grant_lsu, w_grant_ifu;

  assign w_aw_fire   = bus.m_awvalid & bus.m_awready;
  assign w_b_fire    = bus.m_bvalid & bus.m_bready;
  assign w_grant_ok  = (r_state == IDLE) && (r_wcnt == '0);
  assign w_grant_lsu = w_grant_ok && bus.lsu_arvalid;
  assign w_grant_ifu = w_grant_ok && !bus.lsu_arvalid && bus.ifu_arvalid;

  // Outstanding-write counter; simultaneous AW and B fires cancel out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_wcnt <= '0;
    else if (w_aw_fire && !w_b_fire && r_wcnt != WCW'(MAXOUT))
      r_wcnt <= r_wcnt + WCW'(1);
    else if (w_b_fire && !w_aw_fire && r_wcnt != '0)
      r_wcnt <= r_wcnt - WCW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_arid    <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_lsu) begin
        r_araddr  <= bus.lsu_araddr;
        r_arlen   <= 8'd0;
        r_arsize  <= bus.lsu_arsize;
        r_arburst <= 2'b00;
        r_arid    <= 4'd1;
      end else if (w_grant_ifu) begin
        r_araddr  <= bus.ifu_araddr;
        r_arlen   <= bus.ifu_arlen;
        r_arsize  <= IFU_SIZE;
        r_arburst <= 2'b01;
        r_arid    <= 4'd0;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    bus.m_arvalid   = 1'b0;
    bus.m_rready    = 1'b0;
    bus.ifu_arready = 1'b0;
    bus.lsu_arready = 1'b0;
    bus.ifu_rvalid  = 1'b0;
    bus.lsu_rvalid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_lsu)      w_next = AR_LSU;
        else if (w_grant_ifu) w_next = AR_IFU;
      end
      AR_IFU: begin
        bus.m_arvalid   = 1'b1;
        bus.ifu_arready = bus.m_arready;
        if (bus.m_arready) w_next = R_IFU;
      end
      AR_LSU: begin
        bus.m_arvalid   = 1'b1;
        bus.lsu_arready = bus.m_arready;
        if (bus.m_arready) w_next = R_LSU;
      end
      R_IFU: begin
        bus.m_rready   = bus.ifu_rready;
        bus.ifu_rvalid = bus.m_rvalid;
        if (bus.m_rvalid && bus.ifu_rready && bus.m_rlast) w_next = IDLE;
      end
      R_LSU: begin
        bus.m_rready   = bus.lsu_rready;
        bus.lsu_rvalid = bus.m_rvalid;
        if (bus.m_rvalid && bus.lsu_rready && bus.m_rlast) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.m_araddr  = r_araddr;
  assign bus.m_arlen   = r_arlen;
  assign bus.m_arsize  = r_arsize;
  assign bus.m_arburst = r_arburst;
  assign bus.m_arid    = r_arid;

  // Zero-latency R path: payload fans out to both, only the owner sees rvalid.
  assign bus.ifu_rdata = bus.m_rdata;
  assign bus.ifu_rresp = bus.m_rresp;
  assign bus.ifu_rlast = bus.m_rlast;
  assign bus.lsu_rdata = bus.m_rdata;
  assign bus.lsu_rresp = bus.m_rresp;
endmodule
